// File: rtl/dma_cpu_prog_master.sv
// CPU-side programming master for an 8237 DMA controller: byte-wide IOR/IOW cycles with
// configurable setup/strobe/hold timing. Optional macro DMA_PROG_AUTO_CLRBP_EN adds a clear-byte-pointer write before wide requests.
module dma_cpu_prog_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WR,
  input  logic [3:0]  REQ_ADDR,
  input  logic        REQ_WIDE,
  input  logic [15:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [15:0] RSP_RDATA,
  output logic        CS_N,
  output logic        IOR_N,
  output logic        IOW_N,
  output logic [3:0]  ADDR_L,
  output logic [7:0]  DB_OUT,
  output logic        DB_OE,
  input  logic [7:0]  DB_IN,
  input  logic        HLDA
);

  localparam int unsigned CNT_W = 4;
  localparam logic [3:0]  CLRBP_ADDR = 4'hC;
`ifdef DMA_PROG_AUTO_CLRBP_EN
  localparam bit AUTO_CLR = 1'b1;
`else
  localparam bit AUTO_CLR = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP, RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [3:0]         addr_q, addr_d;
  logic               wide_q, wide_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               clr_q, clr_d;
  logic               byte_q, byte_d;
  logic [7:0]         rd_lo_q, rd_lo_d;
  logic [7:0]         rd_hi_q, rd_hi_d;
  logic               ready_q, ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_rdata_q, rsp_rdata_d;
  logic               cs_n_q, cs_n_d;
  logic               ior_n_q, ior_n_d;
  logic               iow_n_q, iow_n_d;
  logic [3:0]         addr_l_q, addr_l_d;
  logic [7:0]         db_out_q, db_out_d;
  logic               db_oe_q, db_oe_d;
  logic               busy_d;
  logic               cyc_wr_d;

  // Next state, then bus outputs derived from the next state so the pins are flop outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wide_d      = wide_q;
    wdata_d     = wdata_q;
    clr_d       = clr_q;
    byte_d      = byte_q;
    rd_lo_d     = rd_lo_q;
    rd_hi_d     = rd_hi_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (ready_q && !HLDA && REQ_VALID) begin
          wr_d    = REQ_WR;
          addr_d  = REQ_ADDR;
          wide_d  = REQ_WIDE;
          wdata_d = REQ_WDATA;
          clr_d   = AUTO_CLR && REQ_WIDE;
          byte_d  = 1'b0;
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = CNT_W'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          // Read data is captured on the edge that ends the strobe.
          if (!(wr_q || clr_q)) begin
            if (byte_q) rd_hi_d = DB_IN;
            else        rd_lo_d = DB_IN;
          end
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          if (clr_q) begin
            clr_d   = 1'b0;
            state_d = GAP;
          end else if (wide_q && !byte_q) begin
            byte_d  = 1'b1;
            state_d = GAP;
          end else begin
            state_d = RESP;
            if (!wr_q) rsp_rdata_d = wide_q ? {rd_hi_q, rd_lo_q} : {8'h00, rd_lo_q};
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (!HLDA) begin
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    cyc_wr_d    = wr_d || clr_d;
    cs_n_d      = !busy_d;
    iow_n_d     = !((state_d == STROBE) && cyc_wr_d);
    ior_n_d     = !((state_d == STROBE) && !cyc_wr_d);
    addr_l_d    = busy_d ? (clr_d ? CLRBP_ADDR : addr_d) : 4'h0;
    db_oe_d     = busy_d && cyc_wr_d;
    db_out_d    = 8'h00;
    if (db_oe_d && !clr_d) db_out_d = byte_d ? wdata_d[15:8] : wdata_d[7:0];
    rsp_valid_d = (state_d == RESP);
    ready_d     = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= 4'h0;
      wide_q      <= 1'b0;
      wdata_q     <= 16'h0000;
      clr_q       <= 1'b0;
      byte_q      <= 1'b0;
      rd_lo_q     <= 8'h00;
      rd_hi_q     <= 8'h00;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      cs_n_q      <= 1'b1;
      ior_n_q     <= 1'b1;
      iow_n_q     <= 1'b1;
      addr_l_q    <= 4'h0;
      db_out_q    <= 8'h00;
      db_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wide_q      <= wide_d;
      wdata_q     <= wdata_d;
      clr_q       <= clr_d;
      byte_q      <= byte_d;
      rd_lo_q     <= rd_lo_d;
      rd_hi_q     <= rd_hi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      cs_n_q      <= cs_n_d;
      ior_n_q     <= ior_n_d;
      iow_n_q     <= iow_n_d;
      addr_l_q    <= addr_l_d;
      db_out_q    <= db_out_d;
      db_oe_q     <= db_oe_d;
    end
  end

  // HLDA gates acceptance immediately, so the bus is never requested while granted away.
  assign REQ_READY = ready_q && !HLDA;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign CS_N      = cs_n_q;
  assign IOR_N     = ior_n_q;
  assign IOW_N     = iow_n_q;
  assign ADDR_L    = addr_l_q;
  assign DB_OUT    = db_out_q;
  assign DB_OE     = db_oe_q;

endmodule

// File: tb/tb_dma_cpu_prog_master.sv
// Directed, table-driven bench for dma_cpu_prog_master at default timing; expectations follow DMA_PROG_AUTO_CLRBP_EN.
module tb_dma_cpu_prog_master;

`ifdef DMA_PROG_AUTO_CLRBP_EN
  localparam bit MAC = 1'b1;
`else
  localparam bit MAC = 1'b0;
`endif

  logic        CLK, RESET_N, REQ_VALID, REQ_READY, REQ_WR, REQ_WIDE;
  logic [3:0]  REQ_ADDR, ADDR_L;
  logic [15:0] REQ_WDATA, RSP_RDATA;
  logic        RSP_VALID, CS_N, IOR_N, IOW_N, DB_OE, HLDA;
  logic [7:0]  DB_OUT, DB_IN;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  dma_cpu_prog_master dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR), .REQ_WIDE(REQ_WIDE), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .CS_N(CS_N), .IOR_N(IOR_N),
    .IOW_N(IOW_N), .ADDR_L(ADDR_L), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .DB_IN(DB_IN),
    .HLDA(HLDA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic        wide;
    logic [15:0] wdata;
    logic [7:0]  rb0, rb1;
    int          hl_on, hl_off;
    int          lat_off, lat_on;
    logic [23:0] cs_off, cs_on;
    logic [35:0] w_off, w_on;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus protocol invariants, sampled every cycle away from the clock edge.
  always @(negedge CLK) begin
    if (chk_en && RESET_N) begin
      if (!IOR_N && !IOW_N) begin
        n_fail++;
        $display("FAIL strobe_overlap: IOR_N=%b IOW_N=%b", IOR_N, IOW_N);
      end
      if (CS_N && (!IOR_N || !IOW_N)) begin
        n_fail++;
        $display("FAIL strobe_without_cs: CS_N=%b IOR_N=%b IOW_N=%b", CS_N, IOR_N, IOW_N);
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (!REQ_READY && w < 20) begin
      @(negedge CLK);
      w++;
    end
    if (!REQ_READY) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: REQ_READY=%b expected 1", REQ_READY);
    end
  endtask

  task automatic run_vec(input vec_t v, output int lat, output logic [23:0] cs_tr,
                         output logic [23:0] iow_tr, output logic [35:0] wlog,
                         output int nrsp, output logic oe_bad);
    int   rd_k = 0;
    logic prev_ior = 1'b1;
    logic prev_iow = 1'b1;
    lat = -1; nrsp = 0; oe_bad = 1'b0; wlog = '0; cs_tr = '1; iow_tr = '1;
    wait_ready();
    REQ_VALID = 1'b1; REQ_WR = v.wr; REQ_ADDR = v.addr; REQ_WIDE = v.wide; REQ_WDATA = v.wdata;
    for (int t = 0; t < 24; t++) begin
      if (t > 0) @(negedge CLK);
      cs_tr[t]  = CS_N;
      iow_tr[t] = IOW_N;
      if (RSP_VALID) begin
        nrsp++;
        if (lat < 0) lat = t;
      end
      if (!IOW_N && prev_iow) wlog = {wlog[23:0], ADDR_L, DB_OUT};
      if ((!IOW_N && !DB_OE) || (!IOR_N && DB_OE) || (CS_N && DB_OE)) oe_bad = 1'b1;
      if (!IOR_N) DB_IN = (rd_k == 0) ? v.rb0 : v.rb1;
      else if (!prev_ior) rd_k++;
      prev_ior = IOR_N;
      prev_iow = IOW_N;
      if (v.hl_on != 0 && t == v.hl_on) HLDA = 1'b1;
      if (v.hl_off != 0 && t == v.hl_off) HLDA = 1'b0;
      if (t == 1) begin
        REQ_VALID = 1'b0; REQ_WR = ~v.wr; REQ_ADDR = ~v.addr; REQ_WIDE = ~v.wide;
        REQ_WDATA = ~v.wdata;
      end
    end
  endtask

  initial begin
    int          lat, nrsp;
    logic [23:0] cs_tr, iow_tr;
    logic [35:0] wlog;
    logic        oe_bad, cs_seen, rdy_seen;

    //          wr    addr  wide  wdata     rb0    rb1    hon hoff lat5 latM cs_off     cs_on      w_off            w_on             rdata
    vecs[0] = '{1'b1, 4'h8, 1'b0, 16'h0040, 8'h00, 8'h00, 0, 0, 5,  5,  24'hFFFFE1, 24'hFFFFE1, 36'h840,         36'h840,         16'h0000};
    vecs[1] = '{1'b0, 4'h3, 1'b0, 16'h0000, 8'hCD, 8'h00, 0, 0, 5,  5,  24'hFFFFE1, 24'hFFFFE1, 36'h0,           36'h0,           16'h00CD};
    vecs[2] = '{1'b1, 4'h0, 1'b1, 16'h1234, 8'h00, 8'h00, 0, 0, 10, 15, 24'hFFFC21, 24'hFF8421, 36'h034012,      36'hC00034012,   16'h00CD};
    vecs[3] = '{1'b0, 4'h1, 1'b1, 16'h0000, 8'hCD, 8'hAB, 0, 0, 10, 15, 24'hFFFC21, 24'hFF8421, 36'h0,           36'hC00,         16'hABCD};
    vecs[4] = '{1'b1, 4'hF, 1'b0, 16'h55AA, 8'h00, 8'h00, 0, 0, 5,  5,  24'hFFFFE1, 24'hFFFFE1, 36'hFAA,         36'hFAA,         16'hABCD};
    vecs[5] = '{1'b0, 4'h2, 1'b0, 16'h0000, 8'h7E, 8'h99, 0, 0, 5,  5,  24'hFFFFE1, 24'hFFFFE1, 36'h0,           36'h0,           16'h007E};
    vecs[6] = '{1'b1, 4'h5, 1'b1, 16'hBEEF, 8'h00, 8'h00, 2, 8, 13, 18, 24'hFFE1E1, 24'hFC21E1, 36'h5EF5BE,      36'hC005EF5BE,   16'h007E};
    vecs[7] = '{1'b0, 4'h7, 1'b1, 16'h0000, 8'h11, 8'h22, 0, 0, 10, 15, 24'hFFFC21, 24'hFF8421, 36'h0,           36'hC00,         16'h2211};

    CLK = 1'b0; RESET_N = 1'b0; REQ_VALID = 1'b0; REQ_WR = 1'b0; REQ_ADDR = 4'h0;
    REQ_WIDE = 1'b0; REQ_WDATA = 16'h0000; DB_IN = 8'h00; HLDA = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_bus", {CS_N, IOR_N, IOW_N, ADDR_L, DB_OUT, DB_OE}, {3'b111, 4'h0, 8'h00, 1'b0});
    check("reset_rsp", {REQ_READY, RSP_VALID, RSP_RDATA}, {1'b0, 1'b0, 16'h0000});
    RESET_N = 1'b1;
    @(negedge CLK);
    check("ready_after_reset", REQ_READY, 1'b1);
    chk_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], lat, cs_tr, iow_tr, wlog, nrsp, oe_bad);
      if (lat < 0) $display("FAIL rsp_timeout vec%0d: no RSP_VALID within 24 cycles", i);
      check($sformatf("latency vec%0d", i), 64'(lat), 64'(MAC ? vecs[i].lat_on : vecs[i].lat_off));
      check($sformatf("cs_trace vec%0d", i), cs_tr, MAC ? vecs[i].cs_on : vecs[i].cs_off);
      check($sformatf("write_log vec%0d", i), wlog, MAC ? vecs[i].w_on : vecs[i].w_off);
      check($sformatf("rsp_count vec%0d", i), 64'(nrsp), 64'd1);
      check($sformatf("db_oe vec%0d", i), oe_bad, 1'b0);
      check($sformatf("rdata vec%0d", i), RSP_RDATA, vecs[i].exp_rd);
      if (i == 0) check("iow_trace vec0", iow_tr, 24'hFFFFF3);
    end

    // HLDA held in IDLE blocks acceptance entirely.
    wait_ready();
    HLDA = 1'b1; REQ_VALID = 1'b1; REQ_WR = 1'b1; REQ_ADDR = 4'h8; REQ_WIDE = 1'b0;
    cs_seen = 1'b0; rdy_seen = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge CLK);
      if (!CS_N) cs_seen = 1'b1;
      if (REQ_READY) rdy_seen = 1'b1;
    end
    check("hlda_idle_ready", rdy_seen, 1'b0);
    check("hlda_idle_cs", cs_seen, 1'b0);
    REQ_VALID = 1'b0;
    @(negedge CLK);
    HLDA = 1'b0;

    // Reset asserted mid-strobe drops the request without a response.
    wait_ready();
    REQ_VALID = 1'b1; REQ_WR = 1'b1; REQ_ADDR = 4'h8; REQ_WIDE = 1'b0; REQ_WDATA = 16'h0040;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    @(negedge CLK);
    check("pre_reset_strobe", {CS_N, IOW_N}, 2'b00);
    RESET_N = 1'b0;
    #1;
    check("reset_mid_strobe", {CS_N, IOW_N, IOR_N, DB_OE, RSP_VALID}, 5'b11100);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    check("ready_after_mid_reset", REQ_READY, 1'b1);
    nrsp = 0;
    for (int t = 0; t < 8; t++) begin
      if (RSP_VALID) nrsp++;
      @(negedge CLK);
    end
    check("no_rsp_after_reset", 64'(nrsp), 64'd0);
    check("rdata_after_reset", RSP_RDATA, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
